// File: rtl/gray_fmt_pkg.sv
// Shared types and the per-pixel formatter for the grey-to-video path.
// Widths are bounded by MaxDw/MaxPpc; callers pass their actual geometry.
package gray_fmt_pkg;

    typedef enum logic [1:0] {
        FMT_YUV422,
        FMT_YUV444,
        FMT_RGB,
        FMT_RSVD
    } fmt_mode_t;

    localparam int unsigned MaxDw  = 16;
    localparam int unsigned MaxPpc = 16;

    typedef logic [MaxDw*MaxPpc-1:0]   gray_word_t;
    typedef logic [3*MaxDw*MaxPpc-1:0] fmt_word_t;

    // Bit-level loops keep the part-select widths constant for any dw/ppc.
    function automatic fmt_word_t fmt_pixels(input fmt_mode_t        mode,
                                             input gray_word_t       data,
                                             input int unsigned      dw,
                                             input int unsigned      ppc,
                                             input logic [MaxDw-1:0] cn);
        fmt_word_t res;
        logic      y;
        res = '0;
        for (int unsigned i = 0; i < MaxPpc; i++) begin
            for (int unsigned b = 0; b < MaxDw; b++) begin
                if (i < ppc && b < dw) begin
                    y = data[i*dw+b];
                    unique case (mode)
                        FMT_YUV444: begin
                            res[3*i*dw+b]        = y;
                            res[3*i*dw+dw+b]     = cn[b];
                            res[3*i*dw+2*dw+b]   = cn[b];
                        end
                        FMT_RGB: begin
                            res[3*i*dw+b]        = y;
                            res[3*i*dw+dw+b]     = y;
                            res[3*i*dw+2*dw+b]   = y;
                        end
                        default: begin
                            res[2*i*dw+b]        = y;
                            res[2*i*dw+dw+b]     = cn[b];
                        end
                    endcase
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// AXI4-Stream register slice: output register plus one skid entry, with a
// registered ready so no combinational path runs from out_ready_i to in_ready_o.
module axis_skid_buffer #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    input  logic [Width-1:0] in_data_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic [Width-1:0] out_data_o,
    input  logic             out_ready_i
);

    logic             out_valid_q, out_valid_d;
    logic [Width-1:0] out_data_q, out_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [Width-1:0] skid_data_q, skid_data_d;
    logic             in_ready_q, in_ready_d;
    logic             out_free, in_fire;

    always_comb begin
        out_free     = !out_valid_q || out_ready_i;
        in_fire      = in_valid_i && in_ready_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (out_free) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = in_fire;
                if (in_fire) skid_data_d = in_data_i;
            end else begin
                out_valid_d = in_fire;
                if (in_fire) out_data_d = in_data_i;
            end
        end else if (in_fire) begin
            // Output is stalled: park the new beat in the skid entry.
            skid_valid_d = 1'b1;
            skid_data_d  = in_data_i;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            in_ready_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;

endmodule

// File: rtl/gray_to_video_fmt.sv
// Registered greyscale-to-video formatter (YUV422 / YUV444 / RGB). Format is
// latched on each accepted start-of-frame beat and applied before buffering.
module gray_to_video_fmt
    import gray_fmt_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned PPC            = 4,
    parameter int unsigned CHROMA_NEUTRAL = 2 ** (DATA_WIDTH - 1)
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [1:0]                     cfg_mode,
    input  logic                           s_axis_gray_tvalid,
    input  logic [DATA_WIDTH*PPC-1:0]      s_axis_gray_tdata,
    input  logic                           s_axis_gray_tuser,
    input  logic                           s_axis_gray_tlast,
    output logic                           s_axis_gray_tready,
    output logic [DATA_WIDTH*PPC*3-1:0]    m_axis_yuv_tdata,
    output logic                           m_axis_yuv_tvalid,
    output logic                           m_axis_yuv_tuser,
    output logic                           m_axis_yuv_tlast,
    input  logic                           m_axis_yuv_tready,
    output logic [1:0]                     active_mode
);

    localparam int unsigned GrayW    = DATA_WIDTH * PPC;
    localparam int unsigned OutW     = 3 * GrayW;
    localparam int unsigned PayloadW = OutW + 2;
    localparam logic [MaxDw-1:0] ChromaN = MaxDw'(CHROMA_NEUTRAL);

    if (PPC % 2 != 0) begin : g_ppc_odd
        $error("gray_to_video_fmt: PPC must be even");
    end
    if (DATA_WIDTH > MaxDw || PPC > MaxPpc) begin : g_too_wide
        $error("gray_to_video_fmt: DATA_WIDTH/PPC exceed gray_fmt_pkg limits");
    end

    fmt_mode_t             active_mode_q, active_mode_d;
    fmt_mode_t             beat_mode;
    gray_word_t            gray_ext;
    fmt_word_t             fmt_full;
    logic                  in_fire, sof_fire;
    logic [PayloadW-1:0]   in_payload, out_payload;

    always_comb begin
        in_fire   = s_axis_gray_tvalid && s_axis_gray_tready;
        sof_fire  = in_fire && s_axis_gray_tuser;
        // The SOF beat itself already uses the newly sampled mode.
        beat_mode = sof_fire ? fmt_mode_t'(cfg_mode) : active_mode_q;
        active_mode_d = beat_mode;
        gray_ext  = '0;
        gray_ext[GrayW-1:0] = s_axis_gray_tdata;
        fmt_full  = fmt_pixels(beat_mode, gray_ext, DATA_WIDTH, PPC, ChromaN);
        in_payload = {s_axis_gray_tuser, s_axis_gray_tlast, fmt_full[OutW-1:0]};
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            active_mode_q <= FMT_YUV422;
        end else begin
            active_mode_q <= active_mode_d;
        end
    end

    axis_skid_buffer #(
        .Width (PayloadW)
    ) u_skid (
        .clk_i       (aclk),
        .rst_ni      (aresetn),
        .in_valid_i  (s_axis_gray_tvalid),
        .in_data_i   (in_payload),
        .in_ready_o  (s_axis_gray_tready),
        .out_valid_o (m_axis_yuv_tvalid),
        .out_data_o  (out_payload),
        .out_ready_i (m_axis_yuv_tready)
    );

    assign m_axis_yuv_tuser = out_payload[PayloadW-1];
    assign m_axis_yuv_tlast = out_payload[PayloadW-2];
    assign m_axis_yuv_tdata = out_payload[OutW-1:0];
    assign active_mode      = active_mode_q;

endmodule

// File: tb/tb_gray_to_video_fmt.sv
// Directed self-checking bench for gray_to_video_fmt (DW=8, PPC=4).
module tb_gray_to_video_fmt;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [1:0]  cfg_mode = 2'd0;
    logic        s_tvalid = 1'b0;
    logic [31:0] s_tdata = '0;
    logic        s_tuser = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tready;
    logic [95:0] m_tdata;
    logic        m_tvalid, m_tuser, m_tlast;
    logic        m_tready = 1'b1;
    logic [1:0]  active_mode;

    int n_checks = 0;
    int n_pass   = 0;

    gray_to_video_fmt #(
        .DATA_WIDTH     (8),
        .PPC            (4),
        .CHROMA_NEUTRAL (128)
    ) dut (
        .aclk               (aclk),
        .aresetn            (aresetn),
        .cfg_mode           (cfg_mode),
        .s_axis_gray_tvalid (s_tvalid),
        .s_axis_gray_tdata  (s_tdata),
        .s_axis_gray_tuser  (s_tuser),
        .s_axis_gray_tlast  (s_tlast),
        .s_axis_gray_tready (s_tready),
        .m_axis_yuv_tdata   (m_tdata),
        .m_axis_yuv_tvalid  (m_tvalid),
        .m_axis_yuv_tuser   (m_tuser),
        .m_axis_yuv_tlast   (m_tlast),
        .m_axis_yuv_tready  (m_tready),
        .active_mode        (active_mode)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        tick();
        tick();
        n_checks++;
        if (m_tvalid !== 1'b0 || m_tuser !== 1'b0 || m_tlast !== 1'b0)
            $display("FAIL reset_sideband: got v=%b u=%b l=%b want 0 0 0",
                     m_tvalid, m_tuser, m_tlast);
        else n_pass++;
        n_checks++;
        if (m_tdata !== 96'h0) $display("FAIL reset_tdata: got %h want 0", m_tdata);
        else n_pass++;
        n_checks++;
        if (s_tready !== 1'b0) $display("FAIL reset_sready: got %b want 0", s_tready);
        else n_pass++;
        n_checks++;
        if (active_mode !== 2'd0) $display("FAIL reset_mode: got %0d want 0", active_mode);
        else n_pass++;
        aresetn = 1'b1;
        tick();
        n_checks++;
        if (s_tready !== 1'b1) $display("FAIL release_sready: got %b want 1", s_tready);
        else n_pass++;
    endtask

    task automatic test_formats();
        logic [1:0]  mode_tab [3];
        logic [95:0] exp_tab  [3];
        mode_tab[0] = 2'd0; exp_tab[0] = 96'h00000000_00000000_8044803380228011;
        mode_tab[1] = 2'd2; exp_tab[1] = 96'h444444_333333_222222_111111;
        mode_tab[2] = 2'd1; exp_tab[2] = 96'h808044_808033_808022_808011;
        m_tready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            cfg_mode = mode_tab[t];
            s_tvalid = 1'b1;
            s_tuser  = 1'b1;
            s_tlast  = 1'b0;
            s_tdata  = 32'h44332211;
            tick();
            s_tvalid = 1'b0;
            s_tuser  = 1'b0;
            n_checks++;
            if (m_tvalid !== 1'b1 || m_tuser !== 1'b1 || m_tdata !== exp_tab[t])
                $display("FAIL format_mode%0d: got v=%b u=%b d=%h want v=1 u=1 d=%h",
                         mode_tab[t], m_tvalid, m_tuser, m_tdata, exp_tab[t]);
            else n_pass++;
            n_checks++;
            if (active_mode !== mode_tab[t])
                $display("FAIL format_active%0d: got %0d want %0d",
                         t, active_mode, mode_tab[t]);
            else n_pass++;
            tick();
            n_checks++;
            if (m_tvalid !== 1'b0) $display("FAIL format_drain%0d: got %b want 0", t, m_tvalid);
            else n_pass++;
        end
    endtask

    task automatic test_mode_latch();
        m_tready = 1'b1;
        cfg_mode = 2'd0; s_tvalid = 1'b1; s_tuser = 1'b1; s_tdata = 32'h04030201;
        tick();
        n_checks++;
        if (m_tdata !== 96'h0000_0000_0000_0000_8004_8003_8002_8001 || active_mode !== 2'd0)
            $display("FAIL latch_sof0: got d=%h m=%0d want 8004800380028001 m=0",
                     m_tdata, active_mode);
        else n_pass++;
        cfg_mode = 2'd2; s_tuser = 1'b0; s_tdata = 32'h08070605;
        tick();
        n_checks++;
        if (m_tdata !== 96'h0000_0000_0000_0000_8008_8007_8006_8005 || active_mode !== 2'd0)
            $display("FAIL latch_midline: got d=%h m=%0d want 8008800780068005 m=0",
                     m_tdata, active_mode);
        else n_pass++;
        s_tuser = 1'b1; s_tdata = 32'h0c0b0a09;
        tick();
        s_tvalid = 1'b0; s_tuser = 1'b0;
        n_checks++;
        if (m_tdata !== 96'h0c0c0c_0b0b0b_0a0a0a_090909 || active_mode !== 2'd2)
            $display("FAIL latch_sof2: got d=%h m=%0d want 0c0c0c0b0b0b0a0a0a090909 m=2",
                     m_tdata, active_mode);
        else n_pass++;
        tick();
    endtask

    // RGB stays active from the previous test, so a beat of {4{k}} formats to {12{k}}.
    task automatic test_back_to_back();
        int          si = 0, ri = 0, outst = 0, cyc = 0;
        logic        prev_stall = 1'b0;
        logic [95:0] prev_data = '0;
        logic [95:0] expv;
        logic [7:0]  k;
        logic [3:0]  pat = 4'b1001;
        logic        in_fire, out_fire;
        while (ri < 64 && cyc < 2000) begin
            if (prev_stall) begin
                n_checks++;
                if (m_tvalid !== 1'b1 || m_tdata !== prev_data)
                    $display("FAIL b2b_stable: got v=%b d=%h want v=1 d=%h",
                             m_tvalid, m_tdata, prev_data);
                else n_pass++;
            end
            n_checks++;
            if (s_tready !== (outst < 2))
                $display("FAIL b2b_sready: got %b want %b (held=%0d)",
                         s_tready, (outst < 2), outst);
            else n_pass++;
            s_tvalid = (si < 64);
            k        = 8'(si + 1);
            s_tdata  = {4{k}};
            s_tuser  = 1'b0;
            s_tlast  = 1'b0;
            m_tready = (cyc < 8) ? pat[cyc % 4] : ($urandom_range(0, 2) != 0);
            in_fire  = s_tvalid && s_tready;
            out_fire = m_tvalid && m_tready;
            if (out_fire) begin
                k    = 8'(ri + 1);
                expv = {12{k}};
                n_checks++;
                if (m_tdata !== expv)
                    $display("FAIL b2b_data%0d: got %h want %h", ri, m_tdata, expv);
                else n_pass++;
                ri++;
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            if (in_fire) si++;
            outst = outst + int'(in_fire) - int'(out_fire);
            cyc++;
            tick();
        end
        n_checks++;
        if (ri != 64) $display("FAIL b2b_count: got %0d beats want 64", ri);
        else n_pass++;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        tick();
        n_checks++;
        if (m_tvalid !== 1'b0) $display("FAIL b2b_no_dup: got v=%b want 0", m_tvalid);
        else n_pass++;
    endtask

    task automatic test_reset_midframe();
        m_tready = 1'b0;
        s_tvalid = 1'b1; s_tuser = 1'b0; s_tdata = 32'h10101010;
        tick();
        tick();
        tick();
        n_checks++;
        if (s_tready !== 1'b0 || m_tvalid !== 1'b1)
            $display("FAIL midrst_full: got sready=%b v=%b want 0 1", s_tready, m_tvalid);
        else n_pass++;
        aresetn = 1'b0;
        tick();
        n_checks++;
        if (m_tvalid !== 1'b0 || s_tready !== 1'b0 || m_tdata !== 96'h0)
            $display("FAIL midrst_in_reset: got v=%b sready=%b d=%h want 0 0 0",
                     m_tvalid, s_tready, m_tdata);
        else n_pass++;
        aresetn = 1'b1;
        s_tvalid = 1'b0;
        tick();
        n_checks++;
        if (m_tvalid !== 1'b0 || s_tready !== 1'b1 || active_mode !== 2'd0)
            $display("FAIL midrst_release: got v=%b sready=%b m=%0d want 0 1 0",
                     m_tvalid, s_tready, active_mode);
        else n_pass++;
        m_tready = 1'b1;
        tick();
        n_checks++;
        if (m_tvalid !== 1'b0) $display("FAIL midrst_no_stale: got v=%b want 0", m_tvalid);
        else n_pass++;
        s_tvalid = 1'b1; s_tdata = 32'h04030201;
        tick();
        s_tvalid = 1'b0;
        n_checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 96'h0000_0000_0000_0000_8004_8003_8002_8001)
            $display("FAIL midrst_first: got v=%b d=%h want v=1 d=8004800380028001",
                     m_tvalid, m_tdata);
        else n_pass++;
        tick();
    endtask

    task automatic test_tlast_rate();
        int         lasts = 0;
        logic [7:0] jb;
        logic       exp_last;
        m_tready = 1'b1;
        s_tuser  = 1'b0;
        for (int j = 0; j < 960; j++) begin
            jb       = j[7:0];
            exp_last = (j % 480 == 479);
            s_tvalid = 1'b1;
            s_tdata  = {24'h0, jb};
            s_tlast  = exp_last;
            tick();
            n_checks++;
            if (m_tvalid !== 1'b1 || m_tlast !== exp_last || m_tdata[15:0] !== {8'h80, jb})
                $display("FAIL tlast_beat%0d: got v=%b l=%b d=%h want v=1 l=%b d=80%h",
                         j, m_tvalid, m_tlast, m_tdata[15:0], exp_last, jb);
            else n_pass++;
            if (m_tlast === 1'b1) lasts++;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        tick();
        n_checks++;
        if (lasts != 2 || m_tvalid !== 1'b0)
            $display("FAIL tlast_total: got lasts=%0d v=%b want 2 0", lasts, m_tvalid);
        else n_pass++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_formats();
        test_mode_latch();
        test_back_to_back();
        test_reset_midframe();
        test_tlast_rate();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
